// File: rtl/wave_pkg.sv
// Definitions shared by the waveform capture (write) side and the display (read) side.
package wave_pkg;

    localparam int NUM_SAMPLES = 256;
    localparam int OFFSET_W    = $clog2(NUM_SAMPLES);
    localparam int ADDR_W      = 9;
    localparam int DISP_W      = 8;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } captureState_t;

endpackage

// File: rtl/wave_capture_fmt.sv
// Converts a signed audio sample to offset-binary display width and flags a
// positive-going zero crossing against the previous sample's sign.
module wave_capture_fmt
    import wave_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic                i_prevNeg,
    output logic [DISP_W-1:0]   o_dispSample,
    output logic                o_negative,
    output logic                o_crossing
);

    // Only the top DISP_W bits reach the display; the low bits are dropped by design.
    logic w_unusedLowBits;

    assign o_negative      = i_sample[SAMPLE_W-1];
    assign o_dispSample    = {~i_sample[SAMPLE_W-1], i_sample[SAMPLE_W-2 -: DISP_W-1]};
    assign o_crossing      = i_prevNeg & ~i_sample[SAMPLE_W-1];
    assign w_unusedLowBits = ^i_sample[SAMPLE_W-DISP_W-1:0];

endmodule

// File: rtl/wave_capture.sv
// Captures NUM_SAMPLES samples per positive zero crossing into one half of a
// double-buffered sample RAM. Define WAVE_CAPTURE_AUTOTRIG_EN to auto-trigger after TIMEOUT_SAMPLES strobes in ARMED.
module wave_capture
    import wave_pkg::*;
#(
    parameter int SAMPLE_W = 16
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    , parameter int TIMEOUT_SAMPLES = 4096
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] new_sample_in,
    input  logic                wave_display_idle,
    output logic [ADDR_W-1:0]   write_address,
    output logic                write_enable,
    output logic [DISP_W-1:0]   write_sample,
    output logic                read_index,
    output logic                frame_done
);

    captureState_t       r_state;
    logic [OFFSET_W-1:0] r_offset;
    logic                r_prevNeg;

    logic [DISP_W-1:0]   w_dispSample;
    logic                w_negative;
    logic                w_crossing;
    logic                w_trigger;

    wave_capture_fmt #(
        .SAMPLE_W (SAMPLE_W)
    ) u_fmt (
        .i_sample     (new_sample_in),
        .i_prevNeg    (r_prevNeg),
        .o_dispSample (w_dispSample),
        .o_negative   (w_negative),
        .o_crossing   (w_crossing)
    );

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    localparam int CNT_W = 13;

    // Timeout keeps DC or silent inputs visible; a real crossing on the same strobe is just the trigger.
    logic [CNT_W-1:0] r_armCount;
    logic [CNT_W-1:0] w_armCountNext;

    assign w_armCountNext = r_armCount + CNT_W'(1);
    assign w_trigger      = w_crossing | (w_armCountNext == CNT_W'(TIMEOUT_SAMPLES));
`else
    assign w_trigger = w_crossing;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ARMED;
            r_offset      <= '0;
            r_prevNeg     <= 1'b0;
            write_address <= '0;
            write_enable  <= 1'b0;
            write_sample  <= '0;
            read_index    <= 1'b0;
            frame_done    <= 1'b0;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
            r_armCount    <= '0;
`endif
        end else begin
            write_enable <= 1'b0;
            frame_done   <= 1'b0;
            if (new_sample_ready) begin
                r_prevNeg <= w_negative;
            end

            case (r_state)
                ARMED: begin
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
                    if (new_sample_ready) begin
                        r_armCount <= w_armCountNext;
                    end
`endif
                    if (new_sample_ready && w_trigger) begin
                        write_enable  <= 1'b1;
                        write_address <= {~read_index, {OFFSET_W{1'b0}}};
                        write_sample  <= w_dispSample;
                        r_offset      <= OFFSET_W'(1);
                        r_state       <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (new_sample_ready) begin
                        write_enable  <= 1'b1;
                        write_address <= {~read_index, r_offset};
                        write_sample  <= w_dispSample;
                        if (r_offset == OFFSET_W'(NUM_SAMPLES - 1)) begin
                            r_offset <= '0;
                            r_state  <= WAIT;
                        end else begin
                            r_offset <= r_offset + OFFSET_W'(1);
                        end
                    end
                end

                // Flip only during blanking so the display never sees a half-written buffer.
                WAIT: begin
                    if (wave_display_idle) begin
                        read_index <= ~read_index;
                        frame_done <= 1'b1;
                        r_state    <= ARMED;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
                        r_armCount <= '0;
`endif
                    end
                end

                default: r_state <= ARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_capture.sv
// Scoreboard bench for wave_capture: stimulus pushes expected RAM writes and
// buffer flips; a negedge monitor pops and compares whatever the DUT emits.
module tb_wave_capture;

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
    } wr_t;

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    localparam bit AUTOTRIG = 1'b1;
`else
    localparam bit AUTOTRIG = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;
    logic        frame_done;

    int   testsRun;
    int   testsFailed;
    wr_t  writeQ[$];
    logic flipQ[$];

    wave_capture dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index),
        .frame_done        (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Independent reference for the display conversion used in long loops.
    function automatic logic [7:0] toDisplay(input logic [15:0] s);
        return {~s[15], s[14:8]};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One cycle of inputs; a strobe that should write pushes its expected RAM write first.
    task automatic applyStimulus(input logic [15:0] sample, input logic strobe, input logic idle,
                                 input logic expWrite, input logic [8:0] expAddr, input logic [7:0] expData);
        @(posedge clk);
        #1;
        new_sample_ready  = strobe;
        new_sample_in     = sample;
        wave_display_idle = idle;
        if (expWrite) begin
            writeQ.push_back('{addr: expAddr, data: expData});
        end
    endtask

    task automatic idleCycles(input int n, input logic idle);
        for (int k = 0; k < n; k++) begin
            applyStimulus(16'h0000, 1'b0, idle, 1'b0, 9'h000, 8'h00);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_write_address"}, 16'(write_address), 16'h0000);
        checkOutput({tag, "_write_enable"},  16'(write_enable),  16'h0000);
        checkOutput({tag, "_write_sample"},  16'(write_sample),  16'h0000);
        checkOutput({tag, "_read_index"},    16'(read_index),    16'h0000);
        checkOutput({tag, "_frame_done"},    16'(frame_done),    16'h0000);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every write strobe and every flip must match the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (write_enable) begin
                if (writeQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write",
                             write_address, write_sample);
                end else begin
                    wr_t exp;
                    exp = writeQ.pop_front();
                    checkOutput("write_address", 16'(write_address), 16'(exp.addr));
                    checkOutput("write_sample",  16'(write_sample),  16'(exp.data));
                end
            end
            if (frame_done) begin
                if (flipQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_frame_done: got pulse with read_index %0d, expected none",
                             read_index);
                end else begin
                    logic expIdx;
                    expIdx = flipQ.pop_front();
                    checkOutput("flip_read_index", 16'(read_index), 16'(expIdx));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] s;
        testsRun          = 0;
        testsFailed       = 0;
        reset             = 1'b1;
        new_sample_ready  = 1'b0;
        new_sample_in     = 16'h0000;
        wave_display_idle = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        reset = 1'b0;

        // First capture: only the negative-to-positive step triggers.
        applyStimulus(16'h0100, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00);
        applyStimulus(16'hFF00, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00);
        applyStimulus(16'h0200, 1'b1, 1'b0, 1'b1, 9'h100, 8'h82);
        applyStimulus(16'h0300, 1'b1, 1'b0, 1'b1, 9'h101, 8'h83);
        for (int i = 2; i < 256; i++) begin
            s = 16'(i * 16'h0137) ^ 16'h5A00;
            applyStimulus(s, 1'b1, (i >= 100 && i < 105), 1'b1, 9'(256 + i), toDisplay(s));
        end
        idleCycles(4, 1'b0);
        checkOutput("capture1_all_written", 16'(writeQ.size()), 16'h0000);
        checkOutput("capture1_read_index", 16'(read_index), 16'h0000);

        // WAIT: strobes write nothing; the last leaves prev_neg set.
        applyStimulus(16'h1234, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00);
        applyStimulus(16'h0800, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00);
        applyStimulus(16'h8000, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00);
        idleCycles(3, 1'b0);
        checkOutput("wait_read_index", 16'(read_index), 16'h0000);

        // Crossing strobe coincident with the flip must not trigger.
        flipQ.push_back(1'b1);
        applyStimulus(16'h0400, 1'b1, 1'b1, 1'b0, 9'h000, 8'h00);
        idleCycles(4, 1'b1);
        applyStimulus(16'h0500, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00);
        idleCycles(2, 1'b0);
        checkOutput("flip_read_index_after", 16'(read_index), 16'h0001);
        checkOutput("flip_single_pulse", 16'(flipQ.size()), 16'h0000);

        // Second capture lands in half 0; conversion extremes included.
        applyStimulus(16'h8000, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b1, 9'h000, 8'h80);
        applyStimulus(16'h7FFF, 1'b1, 1'b0, 1'b1, 9'h001, 8'hFF);
        applyStimulus(16'h8000, 1'b1, 1'b0, 1'b1, 9'h002, 8'h00);
        for (int i = 3; i < 100; i++) begin
            s = 16'(i * 16'h0211);
            applyStimulus(s, 1'b1, 1'b0, 1'b1, 9'(i), toDisplay(s));
        end
        idleCycles(2, 1'b0);
        checkOutput("capture2_partial_written", 16'(writeQ.size()), 16'h0000);

        // Asynchronous reset mid-capture clears outputs without waiting for an edge.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkResetOutputs("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(16'hFFFF, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00);
        applyStimulus(16'h0001, 1'b1, 1'b0, 1'b1, 9'h100, 8'h80);
        applyStimulus(16'h0010, 1'b1, 1'b0, 1'b1, 9'h101, 8'h80);
        idleCycles(3, 1'b0);
        checkOutput("restart_written", 16'(writeQ.size()), 16'h0000);
        checkOutput("restart_read_index", 16'(read_index), 16'h0000);

        // Constant positive input: only the auto-trigger can start a capture.
        pulseReset();
        for (int i = 1; i <= 5000; i++) begin
            logic expW;
            expW = AUTOTRIG && (i >= 4096) && (i < 4096 + 256);
            applyStimulus(16'h1000, 1'b1, 1'b0, expW, 9'(256 + i - 4096), 8'h90);
        end
        idleCycles(3, 1'b0);
        checkOutput("constant_written", 16'(writeQ.size()), 16'h0000);
        checkOutput("constant_read_index", 16'(read_index), 16'h0000);
        checkOutput("final_no_pending_flip", 16'(flipQ.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Write-side partner of the waveform display path. Captures 256 consecutive audio samples into one half of a 512-entry, 8-bit, double-buffered sample RAM.
- Each capture starts at a positive-going zero crossing of the incoming sample stream.
- After a full capture, waits for the display to report idle (vertical blanking), then flips `read_index` so the display reads the fresh half and the next capture goes to the other half.

Parameters:
- SAMPLE_W, 16: width of signed two's-complement input sample.
- NUM_SAMPLES, 256: samples per capture; fixed power of two; sets 8 low address bits.
- TIMEOUT_SAMPLES, 4096: accepted samples in ARMED before auto-trigger (only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- new_sample_ready  in  1  one-cycle strobe: `new_sample_in` valid this cycle
- new_sample_in  in  SAMPLE_W  signed audio sample
- wave_display_idle  in  1  high while display is in vertical blanking; level, any duration
- write_address  out  9  RAM write address {~read_index, offset[7:0]}
- write_enable  out  1  one-cycle RAM write strobe
- write_sample  out  8  offset-binary sample: {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: 7]}
- read_index  out  1  buffer half the display reads; capture writes the other half
- frame_done  out  1  one-cycle pulse coincident with each `read_index` toggle

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous, active-high.
- Outputs and reset values: all outputs registered. On reset, `write_address`, `write_enable`, `write_sample`, `read_index` and `frame_done` are 0. Reset also sets state ARMED, offset 0 and `prev_neg` 0.
- `prev_neg`: updated to `new_sample_in` MSB on every strobe, in every state, including the strobe that causes a transition.
- ARMED:
  - On a strobe with `prev_neg`=1 and MSB=0 (trigger), that sample is written at offset 0, offset becomes 1, and state goes to ACTIVE.
  - Any other strobe writes nothing.
- ACTIVE:
  - Each strobe writes the sample at the current offset, then offset increments.
  - The strobe written at offset 255 sets offset to 0 and state to WAIT.
  - Exactly NUM_SAMPLES writes per capture. Zero-crossing detection is ignored.
- WAIT:
  - Strobes write nothing.
  - When `wave_display_idle`=1, the next cycle `read_index` toggles, `frame_done` pulses and state returns to ARMED.
  - A strobe in that same cycle only updates `prev_neg`; it cannot trigger.
- Write latency:
  - `write_enable`, `write_address` and `write_sample` update the cycle after the accepted strobe.
  - `write_enable` is high for exactly one cycle per write.
  - `write_address`/`write_sample` hold their last value when `write_enable`=0.
- Target half: `write_address[8]` is always `~read_index` as it stands when the write is issued. `read_index` never changes during ACTIVE, so a capture never crosses halves.
- Strobe timing: back-to-back strobes on consecutive cycles are supported; every one is processed.
- Idle outside WAIT: `wave_display_idle` asserted in ARMED or ACTIVE has no effect; it is not latched.
- Reset mid-capture: the partial capture is abandoned and `read_index` returns to 0. RAM contents are not cleared.
- Conversion arithmetic: a sample of 0x0000 maps to 0x80, 0x7FFF to 0xFF, 0x8000 to 0x00.

Optional Feature:
- Macro: WAVE_CAPTURE_AUTOTRIG_EN.
- Defined:
  - A 13-bit counter clears on entry to ARMED and increments on each strobe in ARMED.
  - The strobe that brings the count to TIMEOUT_SAMPLES is treated as a trigger even without a zero crossing. This keeps DC or silent inputs visible.
  - A genuine crossing on that same strobe is simply the trigger; no double action.
- Undefined: ARMED waits indefinitely for a crossing; the counter is absent.

Decomposition:
- Shared package (`wave_pkg`):
  - capture state encoding ARMED/ACTIVE/WAIT;
  - NUM_SAMPLES;
  - RAM address width 9;
  - display sample width 8.
  These are shared with the display side.
- Sub-module: `wave_capture_fmt`, combinational SAMPLE_W-to-8-bit offset-binary conversion plus crossing detect (sign of current sample vs `prev_neg`). The FSM, offset counter and flip logic stay in the top.

Test Plan:
- Reset then strobes 0x0100, 0xFF00, 0x0200, 0x0300, ... → no write for the first two; 0x0200 written at address 0x100 with data 0x82, then 0x0300 at 0x101 with data 0x83.
- Trigger, then 256 back-to-back strobes, `wave_display_idle`=0 → exactly 256 `write_enable` pulses at addresses 0x100–0x1FF, then none; `read_index` stays 0.
- From WAIT, raise `wave_display_idle` for 5 cycles → one `frame_done` pulse, `read_index`=1; the next capture writes 0x000–0x0FF.
- Assert `reset` after 100 writes of a capture → all outputs 0 immediately; a following crossing restarts the capture at offset 0 in half 1.
- Constant 0x1000 input for 5000 strobes → with WAVE_CAPTURE_AUTOTRIG_EN, capture starts at strobe 4096 with data 0x90; without it, no writes ever.
- Idle pulse during ACTIVE and a negative-to-positive strobe coincident with the WAIT→ARMED flip → no flip during ACTIVE; the coincident strobe does not trigger.
